// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point add/subtract datapath.
// Holds the default widths and the post-add normalizer state encoding.
package fp_add_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int EXP_MAX    = (1 << EXP_W_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/fp_add_normalizer.sv
// Post-add normalizer: iteratively shifts the mantissa sum into place, adjusting
// the exponent, rounding half-to-even on right shifts and flagging zero/ovf/unf.
module fp_add_normalizer
  import fp_add_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W:0]   mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              zero_flag,
  output logic              ovf_flag,
  output logic              unf_flag
);

  localparam logic [EXP_W-1:0] EXP_TOP = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_OVF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  norm_state_e       state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W:0]   mant_q, mant_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state and one normalization action per NORM cycle
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = sign_in;
          zero_d = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (exp_in == EXP_TOP) begin
            exp_d   = EXP_TOP;
            mant_d  = '0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            // Denormal inputs carry exponent 0 but scale like exponent 1
            exp_d   = (exp_in == '0) ? EXP_ONE : exp_in;
            mant_d  = mant_in;
            state_d = NORM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          sign_d  = 1'b0;
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (mant_q[MANT_W]) begin
          if (exp_q == EXP_OVF) begin
            exp_d   = EXP_TOP;
            mant_d  = '0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            // A rounding re-carry lands in bit MANT_W again and is caught next cycle
            exp_d  = exp_q + EXP_ONE;
            mant_d = (mant_q >> 1) + {{MANT_W{1'b0}}, mant_q[0] & mant_q[1]};
          end
        end else if (mant_q[MANT_W-1]) begin
          state_d = DONE;
        end else if (exp_q == EXP_ONE) begin
          exp_d   = '0;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sign_out  = sign_q;
  assign exp_out   = exp_q;
  assign mant_out  = mant_q[MANT_W-1:0];
  assign zero_flag = zero_q;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;

endmodule
